// File: rtl/alarm_clock_pkg.sv
// Shared types and field limits for the alarm clock controller.
package alarm_clock_pkg;

    localparam int unsigned HH_W   = 5;
    localparam int unsigned MS_W   = 6;
    localparam int unsigned RING_W = 8;
    localparam int unsigned HH_MAX = 23;
    localparam int unsigned MM_MAX = 59;
    localparam int unsigned SS_MAX = 59;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_T_HH = 3'd1,
        SET_T_MM = 3'd2,
        SET_A_HH = 3'd3,
        SET_A_MM = 3'd4
    } mode_e;

endpackage

// File: rtl/alarm_clock_ctrl_wrap_counter.sv
// Modular up-counter 0..MAX with synchronous clear; wrap flags the terminal count.
module wrap_counter #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = (q == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: timekeeping carry chain, set-mode FSM, alarm compare and ring timeout.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned RING_SECS = 60
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1s,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [HH_W-1:0] time_hh,
    output logic [MS_W-1:0] time_mm,
    output logic [MS_W-1:0] time_ss,
    output logic [HH_W-1:0] alarm_hh,
    output logic [MS_W-1:0] alarm_mm,
    output logic            alarm_armed,
    output logic            ring,
    output logic [2:0]      mode
);

    mode_e             state;
    logic [RING_W-1:0] ring_cnt;

    logic inc_evt, time_run, enter_set_t;
    logic ss_en, mm_en, hh_en, ahh_en, amm_en;
    logic ss_wrap, mm_wrap, hh_wrap, ahh_wrap_unused, amm_wrap_unused;
    logic ss_carry, mm_carry;
    logic trigger, stop;
    logic [MS_W-1:0] mm_next;
    logic [HH_W-1:0] hh_next;

    // btn_mode has priority over btn_inc in the same cycle
    assign inc_evt     = btn_inc & ~btn_mode;
    assign time_run    = (state == RUN) | (state == SET_A_HH) | (state == SET_A_MM);
    assign enter_set_t = (state == RUN) & btn_mode & ~ring;

    assign ss_en    = tick_1s & time_run;
    assign ss_carry = ss_en & ss_wrap;
    assign mm_carry = ss_carry & mm_wrap;
    assign mm_en    = ss_carry | ((state == SET_T_MM) & inc_evt);
    assign hh_en    = mm_carry | ((state == SET_T_HH) & inc_evt);
    assign ahh_en   = (state == SET_A_HH) & inc_evt;
    assign amm_en   = (state == SET_A_MM) & inc_evt;

    // Time value that a tick at ss=59 would produce, for the alarm compare
    assign mm_next = mm_wrap ? '0 : time_mm + MS_W'(1);
    assign hh_next = !mm_wrap ? time_hh : (hh_wrap ? '0 : time_hh + HH_W'(1));

    assign trigger = (state == RUN) & alarm_armed & tick_1s & ss_wrap
                   & (mm_next == alarm_mm) & (hh_next == alarm_hh);
    assign stop    = (state == RUN) & (btn_mode | (inc_evt & alarm_armed));

    wrap_counter #(.W(MS_W), .MAX(SS_MAX)) u_ss (
        .clk(clk), .rst(rst), .en(ss_en), .clr(enter_set_t), .q(time_ss), .wrap(ss_wrap)
    );
    wrap_counter #(.W(MS_W), .MAX(MM_MAX)) u_mm (
        .clk(clk), .rst(rst), .en(mm_en), .clr(1'b0), .q(time_mm), .wrap(mm_wrap)
    );
    wrap_counter #(.W(HH_W), .MAX(HH_MAX)) u_hh (
        .clk(clk), .rst(rst), .en(hh_en), .clr(1'b0), .q(time_hh), .wrap(hh_wrap)
    );
    wrap_counter #(.W(MS_W), .MAX(MM_MAX)) u_amm (
        .clk(clk), .rst(rst), .en(amm_en), .clr(1'b0), .q(alarm_mm), .wrap(amm_wrap_unused)
    );
    wrap_counter #(.W(HH_W), .MAX(HH_MAX)) u_ahh (
        .clk(clk), .rst(rst), .en(ahh_en), .clr(1'b0), .q(alarm_hh), .wrap(ahh_wrap_unused)
    );

    // Mode sequencing, arm toggle and ring timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            alarm_armed <= 1'b0;
            ring        <= 1'b0;
            ring_cnt    <= '0;
        end else begin
            case (state)
                RUN:      if (btn_mode && !ring) state <= SET_T_HH;
                SET_T_HH: if (btn_mode) state <= SET_T_MM;
                SET_T_MM: if (btn_mode) state <= SET_A_HH;
                SET_A_HH: if (btn_mode) state <= SET_A_MM;
                SET_A_MM: if (btn_mode) state <= RUN;
                default:  state <= RUN;
            endcase

            if ((state == RUN) && inc_evt) begin
                alarm_armed <= ~alarm_armed;
            end

            if (stop) begin
                ring     <= 1'b0;
                ring_cnt <= '0;
            end else if (trigger) begin
                ring     <= 1'b1;
                ring_cnt <= RING_W'(RING_SECS);
            end else if (ring && tick_1s) begin
                ring_cnt <= ring_cnt - RING_W'(1);
                if (ring_cnt <= RING_W'(1)) begin
                    ring <= 1'b0;
                end
            end
        end
    end

    assign mode = 3'(state);

endmodule
